adc_snapshot_capture: RTL and testbench
=======================================

Name: adc_snapshot_capture

Overview:
- Consumes one 128-bit ADC channel stream from the RF data converter (8 x 16-bit signed samples per beat) in the ADC user clock domain.
- Keeps a circular record in block RAM of DEPTH beats, with a programmable pre-trigger portion.
- Triggers on a software pulse or a sample-level threshold crossing.
- Plays the frozen record out as one AXI-Stream packet, with tlast, to the downstream DMA/packetiser.

Parameters:
- DATA_W, 128, stream width; must equal LANES*SAMPLE_W.
- SAMPLE_W, 16, signed sample width.
- LANES, 8, samples per beat; lane 0 = tdata[15:0].
- DEPTH, 1024, record length in beats; power of two.
- ADDR_W, 10, log2(DEPTH).

Ports:
- adc_usr_clk  in  1  ADC user clock; the only clock.
- adc_usr_rstb  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  DATA_W  ADC samples.
- s_axis_tvalid  in  1  sample beat valid.
- s_axis_tready  out  1  always 1 out of reset; ADC cannot be back-pressured.
- arm  in  1  single-cycle pulse; starts a capture.
- abort  in  1  single-cycle pulse; returns to IDLE.
- sw_trig  in  1  single-cycle software trigger.
- thr_en  in  1  enables the threshold trigger.
- threshold  in  SAMPLE_W  signed threshold.
- pre_len  in  ADDR_W  pre-trigger beats; sampled on arm; 0..DEPTH-1.
- m_axis_tdata  out  DATA_W  record data.
- m_axis_tvalid  out  1  record beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last record beat.
- busy  out  1  high in PRE, ARMED, POST, READ.
- done  out  1  record fully read out; held until next arm.
- trig_src  out  1  0 = software trigger, 1 = threshold trigger; valid while done.
- trig_lane  out  3  lowest lane that crossed; 0 for a software trigger.

Behaviour:
- Reset values (adc_usr_rstb=0 on a clock edge):
  - state=IDLE, wr_ptr=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - busy=0, done=0, trig_src=0, trig_lane=0.
  - s_axis_tready=0 during reset, 1 from the first cycle after reset.
- A "write" means: a beat with s_axis_tvalid=1 is stored at wr_ptr, and wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- IDLE:
  - Input beats are discarded.
  - arm -> PRE, or -> ARMED if pre_len=0. On this transition: latch pre_len, clear done, clear trig_src/trig_lane.
- PRE:
  - Every valid beat is written; a count runs to the latched pre_len.
  - Triggers are ignored, which guarantees a full pre-history.
  - When the count is reached -> ARMED.
- ARMED:
  - Writes continue circularly.
  - Trigger = valid beat AND (sw_trig OR (thr_en AND any lane, signed, > threshold)).
  - If sw_trig and the threshold fire in the same beat, trig_src=0.
  - The triggering beat is written and is post-beat 1. trig_addr = its address.
  - -> POST.
  - If sw_trig is asserted with no valid beat in that cycle, it is held pending and applies to the next valid beat.
- POST:
  - Write until DEPTH - pre_len post beats are stored, counting the trigger beat.
  - Then -> READ with rd_start = (trig_addr - pre_len) mod DEPTH.
  - From this point input beats are discarded (tready stays 1).
- READ:
  - Emits exactly DEPTH beats from rd_start, wrapping at DEPTH.
  - The trigger beat is always packet index pre_len.
  - RAM read latency is 1 cycle; a prefetch/skid register sustains 1 beat/cycle while m_axis_tready=1.
  - tdata, tvalid and tlast hold stable while tvalid=1 and tready=0.
  - First tvalid occurs no later than 2 cycles after entering READ.
  - tlast=1 on beat DEPTH only.
  - Handshake on the tlast beat -> DONE.
- DONE: done=1, busy=0; arm -> as from IDLE.
- abort:
  - In PRE, ARMED or POST: abort -> IDLE next cycle, done stays 0, no output beats.
  - In READ or DONE: abort is ignored, so packets are never truncated.
- arm while busy: ignored.
- Simultaneous arm and abort in IDLE/DONE: abort wins; stay in or go to IDLE, done cleared.
- Reset mid-operation: full return to reset values. Buffer contents are not cleared and are never emitted without a new capture.

Test Plan:
- Ramp input (beat n = n in every lane), pre_len=16, sw_trig on input beat 100 after arm -> packet of 1024 beats, beat 0 = 84, beat 16 = 100, tlast on beat 1023 = 1107, trig_src=0, done=1.
- threshold=1000, thr_en=1, lane 5 jumps to 1001 on beat 300 (lane 2 = 1000, not greater) -> trigger at beat 300, trig_src=1, trig_lane=5.
- sw_trig during PRE with pre_len=64 -> ignored; later sw_trig captures correctly; an abort issued in ARMED on a separate run -> IDLE, no m_axis beats, done=0.
- Random m_axis_tready (50%) plus tvalid gaps on s_axis -> all 1024 beats in order with none dropped; data stable while stalled; exactly one tlast.
- pre_len=0 with trigger at wr_ptr=1020 -> wrapped readout starts at address 1020, beat 0 = trigger beat.
- Reset pulsed mid-READ -> next cycle m_axis_tvalid=0, busy=0, done=0; a new arm and capture behave normally.

Source files
------------

// File: rtl/adc_snapshot_capture.sv
// adc_snapshot_capture: circular ADC snapshot with pre-trigger history, replayed as one AXI-Stream packet
module adc_snapshot_capture #(
    parameter int DATA_W   = 128,
    parameter int SAMPLE_W = 16,
    parameter int LANES    = 8,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic                adc_usr_clk,
    input  logic                adc_usr_rstb,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                arm,
    input  logic                abort,
    input  logic                sw_trig,
    input  logic                thr_en,
    input  logic [SAMPLE_W-1:0] threshold,
    input  logic [ADDR_W-1:0]   pre_len,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                done,
    output logic                trig_src,
    output logic [2:0]          trig_lane
);
    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, READ, DONE} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] wr_ptr, pre_q, trig_addr, rd_addr, rd_addr_n, rd_start, idx;
    logic [ADDR_W:0]   cnt, post_need;
    logic [2:0]        hit_lane;
    logic              thr_hit, sw_pend, sw_any, we, fire, start, enter_read, hs, out_valid;

    always_comb begin
        thr_hit  = 1'b0;
        hit_lane = 3'd0;
        for (int i = LANES - 1; i >= 0; i--)
            if ($signed(s_axis_tdata[i*SAMPLE_W +: SAMPLE_W]) > $signed(threshold)) begin
                thr_hit  = 1'b1;
                hit_lane = 3'(i);
            end
    end

    assign sw_any    = sw_trig | sw_pend;
    assign we        = s_axis_tvalid && (state inside {PRE, ARMED, POST});
    assign fire      = state == ARMED && !abort && s_axis_tvalid && (sw_any || (thr_en && thr_hit));
    assign start     = arm && !abort && (state inside {IDLE, DONE});
    assign post_need = (ADDR_W+1)'(DEPTH) - {1'b0, pre_q};
    assign hs        = out_valid && m_axis_tready;
    assign rd_start  = (state == ARMED ? wr_ptr : trig_addr) - pre_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (arm) state_n = abort ? IDLE : (pre_len == '0 ? ARMED : PRE);
            PRE:     state_n = abort ? IDLE : (we && cnt + 1'b1 == {1'b0, pre_q}) ? ARMED : PRE;
            ARMED:   state_n = abort ? IDLE : !fire ? ARMED : (post_need == (ADDR_W+1)'(1)) ? READ : POST;
            POST:    state_n = abort ? IDLE : (we && cnt + 1'b1 == post_need) ? READ : POST;
            READ:    state_n = (hs && m_axis_tlast) ? DONE : READ;
            default: state_n = IDLE;
        endcase
        enter_read = state_n == READ && state != READ;
        // Address the beat to be shown next cycle so the registered RAM output never stalls the stream
        rd_addr_n  = enter_read ? rd_start : hs ? rd_addr + 1'b1 : rd_addr;
    end

    always_ff @(posedge adc_usr_clk)
        state <= !adc_usr_rstb ? IDLE : state_n;

    always_ff @(posedge adc_usr_clk) begin
        if (!adc_usr_rstb) begin
            wr_ptr        <= '0;
            pre_q         <= '0;
            cnt           <= '0;
            trig_addr     <= '0;
            rd_addr       <= '0;
            idx           <= '0;
            sw_pend       <= 1'b0;
            out_valid     <= 1'b0;
            trig_src      <= 1'b0;
            trig_lane     <= 3'd0;
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            if (we)
                wr_ptr <= wr_ptr + 1'b1;
            sw_pend <= state == ARMED && state_n == ARMED && sw_any;
            if (start) begin
                pre_q     <= pre_len;
                cnt       <= '0;
                trig_src  <= 1'b0;
                trig_lane <= 3'd0;
            end else if (fire) begin
                cnt       <= (ADDR_W+1)'(1);
                trig_addr <= wr_ptr;
                trig_src  <= !sw_any;
                trig_lane <= sw_any ? 3'd0 : hit_lane;
            end else if (we)
                cnt <= cnt + 1'b1;
            out_valid <= state_n == READ;
            rd_addr   <= rd_addr_n;
            idx       <= enter_read ? '0 : hs ? idx + 1'b1 : idx;
        end
    end

    always_ff @(posedge adc_usr_clk) begin
        if (we)
            mem[wr_ptr] <= s_axis_tdata;
        dout <= mem[rd_addr_n];
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_valid && (&idx);
    assign m_axis_tdata  = out_valid ? dout : '0;
    assign busy          = state inside {PRE, ARMED, POST, READ};
    assign done          = state == DONE;
endmodule

// File: tb/tb_adc_snapshot_capture.sv
// tb_adc_snapshot_capture: randomized capture scenarios checked against a record-level model
module tb_adc_snapshot_capture;
    localparam int DEPTH = 1024;
    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         arm = 1'b0, abort = 1'b0, sw_trig = 1'b0, thr_en = 1'b0;
    logic [15:0]  threshold = '0;
    logic [9:0]   pre_len = '0;
    logic [127:0] m_tdata;
    logic         m_tvalid, m_tlast, busy, done, trig_src;
    logic         m_tready = 1'b0;
    logic [2:0]   trig_lane;

    always #5 clk = ~clk;

    adc_snapshot_capture dut (
        .adc_usr_clk(clk), .adc_usr_rstb(rstb),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .arm(arm), .abort(abort), .sw_trig(sw_trig), .thr_en(thr_en),
        .threshold(threshold), .pre_len(pre_len),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .busy(busy), .done(done),
        .trig_src(trig_src), .trig_lane(trig_lane)
    );

    int checks = 0, failures = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 capturing, 2 reading, 3 done
    int           phase = 0, pre_l = 0, pre_cnt = 0, post_cnt = 0, ti = 0, rd_idx = 0;
    int           novalid = 0, tlast_cnt = 0;
    bit           trig_m = 0, pend_m = 0, src_m = 0, rdy_m = 0, hs_next = 0, mon_en = 0, seen_v = 0;
    logic [2:0]   lane_m = 3'd0;
    logic [127:0] wq[$];
    logic [127:0] expq[$];

    // Stimulus knobs
    int vprob = 100, rprob = 100, beat_n = 0;
    int sw_beat1 = -1, sw_beat2 = -1, spike_a = -1, spike_b = -1, arm_beat = -1;
    bit rnd_data = 0, sw_gap = 0;

    function automatic logic [127:0] ramp(int n);
        return {8{16'(n)}};
    endfunction

    function automatic logic [127:0] rand_beat();
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'($urandom_range(2000)) - 16'd1000;
        return d;
    endfunction

    function automatic int first_cross(logic [127:0] d, logic [15:0] t);
        for (int i = 0; i < 8; i++) if ($signed(d[i*16 +: 16]) > $signed(t)) return i;
        return -1;
    endfunction

    task automatic model();
        int h;
        rdy_m = rstb;
        if (!rstb) begin
            phase = 0; src_m = 0; lane_m = 3'd0;
            return;
        end
        if (phase == 2) begin
            if (hs_next) begin
                rd_idx++;
                if (rd_idx == DEPTH) phase = 3;
            end
            return;
        end
        if (phase == 0 || phase == 3) begin
            if (arm) begin
                if (abort) phase = 0;
                else begin
                    phase = 1; wq.delete(); pre_l = int'(pre_len); pre_cnt = 0;
                    trig_m = 0; pend_m = 0; src_m = 0; lane_m = 3'd0;
                end
            end
            return;
        end
        if (abort) begin
            phase = 0;
            return;
        end
        if (!s_tvalid) begin
            if (pre_cnt >= pre_l && !trig_m && sw_trig) pend_m = 1;
            return;
        end
        wq.push_back(s_tdata);
        if (pre_cnt < pre_l) begin
            pre_cnt++;
            return;
        end
        if (!trig_m) begin
            h = first_cross(s_tdata, threshold);
            if (sw_trig || pend_m || (thr_en && h >= 0)) begin
                trig_m = 1; ti = wq.size() - 1; post_cnt = 0;
                src_m = !(sw_trig || pend_m);
                lane_m = src_m ? 3'(h) : 3'd0;
            end
        end
        if (trig_m) begin
            post_cnt++;
            if (post_cnt == DEPTH - pre_l) begin
                expq.delete();
                for (int k = 0; k < DEPTH; k++) expq.push_back(wq[ti - pre_l + k]);
                phase = 2; rd_idx = 0; novalid = 0; seen_v = 0;
            end
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        chk("s_tready", s_tready, rdy_m);
        chk("busy", busy, phase == 1 || phase == 2);
        chk("done", done, phase == 3);
        chk("trig_src", trig_src, src_m);
        chk("trig_lane", trig_lane, lane_m);
        if (phase == 2) begin
            if (m_tvalid) begin
                seen_v = 1;
                chk("tdata", m_tdata, expq[rd_idx]);
                chk("tlast", m_tlast, rd_idx == DEPTH - 1);
                if (m_tready && m_tlast) tlast_cnt++;
            end else begin
                novalid++;
                chk("tvalid_read", m_tvalid, seen_v || novalid > 2);
            end
        end else
            chk("tvalid_idle", m_tvalid, 1'b0);
        hs_next = m_tvalid && m_tready;
    end

    task automatic step();
        @(posedge clk);
        model();
        mon_en = 1;
        #1;
        arm = 0; abort = 0; sw_trig = 0;
    endtask

    task automatic drive();
        bit v;
        v = $urandom_range(99) < vprob;
        m_tready = $urandom_range(99) < rprob;
        s_tvalid = v;
        s_tdata = rnd_data ? rand_beat() : ramp(beat_n);
        if (v) begin
            if (beat_n == spike_a || beat_n == spike_b) begin
                s_tdata[80 +: 16] = 16'd1001;
                s_tdata[32 +: 16] = 16'd1000;
            end
            if (beat_n == arm_beat) arm = 1;
            if (sw_gap && beat_n == sw_beat2) begin
                s_tvalid = 0; sw_trig = 1;
                step();
                s_tvalid = 1; sw_gap = 0;
            end else if (beat_n == sw_beat1 || beat_n == sw_beat2) sw_trig = 1;
            beat_n++;
        end
        step();
    endtask

    task automatic do_arm(int pl);
        pre_len = 10'(pl); arm = 1; s_tvalid = 0; tlast_cnt = 0;
        step();
        beat_n = 0;
    endtask

    task automatic wait_done(string nm);
        int c = 0;
        while (phase != 3 && c < 8000) begin
            drive();
            c++;
        end
        chk(nm, done, 1'b1);
        chk({nm, "_tlast_count"}, tlast_cnt, 1);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            s_tvalid = 0;
            step();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] t;
        int c;
        repeat (3) step();
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tdata", m_tdata, 128'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_trig_src", trig_src, 1'b0);
        chk("rst_trig_lane", trig_lane, 3'd0);
        chk("rst_tready", s_tready, 1'b0);
        rstb = 1;
        step();
        chk("tready_after_rst", s_tready, 1'b1);

        // Ramp, software trigger on beat 100, pre_len 16
        sw_beat1 = 100;
        do_arm(16);
        wait_done("ramp_done");
        chk("ramp_b0", expq[0], {8{16'd84}});
        chk("ramp_b16", expq[16], {8{16'd100}});
        chk("ramp_b1023", expq[1023], {8{16'd1107}});
        chk("ramp_src", trig_src, 1'b0);
        abort = 1;
        step();
        chk("abort_in_done_ignored", done, 1'b1);

        // Threshold trigger with gaps and random back-pressure
        sw_beat1 = -1; rnd_data = 1; thr_en = 1; threshold = 16'd1000;
        vprob = 70; rprob = 50; spike_a = 50; spike_b = 300;
        do_arm(200);
        wait_done("thr_done");
        chk("thr_ti", ti, 300);
        t = expq[200];
        chk("thr_lane5_val", t[80 +: 16], 16'd1001);
        chk("thr_lane2_val", t[32 +: 16], 16'd1000);
        chk("thr_src", trig_src, 1'b1);
        chk("thr_lane", trig_lane, 3'd5);

        // sw_trig during PRE ignored, later sw_trig via pending gap, arm while busy ignored
        thr_en = 0; spike_a = -1; spike_b = -1; rnd_data = 0; vprob = 100;
        sw_beat1 = 10; sw_beat2 = 150; sw_gap = 1; arm_beat = 400;
        do_arm(64);
        wait_done("pre_sw_done");
        chk("pre_sw_b0", expq[0], {8{16'd86}});
        chk("pre_sw_b64", expq[64], {8{16'd150}});
        chk("pre_sw_src", trig_src, 1'b0);
        arm = 1; abort = 1;
        step();
        chk("arm_abort_done", done, 1'b0);
        chk("arm_abort_busy", busy, 1'b0);

        // Abort while ARMED
        sw_beat1 = -1; sw_beat2 = -1; arm_beat = -1;
        do_arm(32);
        repeat (50) drive();
        abort = 1;
        step();
        chk("abort_busy", busy, 1'b0);
        idle(20);
        chk("abort_done", done, 1'b0);

        // Reset in the middle of readout
        rnd_data = 1; rprob = 50; sw_beat1 = 20;
        do_arm(8);
        c = 0;
        while (!(phase == 2 && rd_idx >= 100) && c < 6000) begin
            drive();
            c++;
        end
        chk("reach_read", busy, 1'b1);
        rstb = 0; s_tvalid = 0;
        step();
        chk("midrst_tvalid", m_tvalid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        rstb = 1;
        idle(3);

        // pre_len 0, trigger written at address 1020, readout wraps
        rnd_data = 0; rprob = 100; sw_beat1 = 1020;
        do_arm(0);
        wait_done("wrap_done");
        chk("wrap_b0", expq[0], {8{16'd1020}});
        chk("wrap_b1023", expq[1023], {8{16'd2043}});
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
